// File: rtl/rbz_spi_regs_if.sv
// Pin bundle for rbz_spi_regs: SPI slave inputs, frame strobe and the
// double-buffered register outputs.
interface rbz_spi_regs_if;
  logic        i_sclk;
  logic        i_mosi;
  logic        i_ss_n;
  logic        i_frame_end;
  logic [63:0] o_regs;
  logic [3:0]  o_pending;
  logic        o_commit;
  logic [7:0]  o_err_count;

  modport master (
    output i_sclk, i_mosi, i_ss_n, i_frame_end,
    input  o_regs, o_pending, o_commit, o_err_count
  );

  modport slave (
    input  i_sclk, i_mosi, i_ss_n, i_frame_end,
    output o_regs, o_pending, o_commit, o_err_count
  );
endinterface

// File: rtl/rbz_spi_regs.sv
// SPI-written register bank: 20-bit writes land in staging registers and are
// copied into the live registers atomically at the next frame boundary.
module rbz_spi_regs #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  rbz_spi_regs_if.slave bus
);

  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_WAIT_IDLE,
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_d, mosi_d, ss_d;
  logic                   sclk_s, ss_s;
  logic                   sclk_rise, ss_fall, ss_rise;

  logic [FLUSH_W-1:0]     flush_cnt;
  logic [4:0]             bit_cnt;
  logic [19:0]            shift;
  logic                   accept, reject;

  logic [3:0][15:0]       staging, live;
  logic [3:0]             pending;
  logic                   commit_q;
  logic [7:0]             err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
      mosi_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.i_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.i_ss_n};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      mosi_d    <= mosi_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;

  // After reset the synchronizers hold forced idle levels; wait until they
  // carry real pin values and ss_n is seen high, so a transaction cut by
  // reset is never decoded from its middle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FLUSH;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FLUSH) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      S_FLUSH:     if (flush_cnt == FLUSH_W'(SYNC_STAGES)) state_nxt = S_WAIT_IDLE;
      S_WAIT_IDLE: if (ss_s) state_nxt = S_IDLE;
      S_IDLE:      if (ss_fall) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (ss_rise) begin
          state_nxt = S_IDLE;
          if (bit_cnt == 5'd20 && shift[19:18] == 2'b00) accept = 1'b1;
          else                                           reject = 1'b1;
        end
      end
      default:     state_nxt = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (state == S_IDLE && ss_fall) begin
      bit_cnt <= '0;
    end else if (state == S_ACTIVE && sclk_rise && !ss_s) begin
      shift <= {shift[18:0], mosi_d};
      if (bit_cnt != 5'd21) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // A write landing with frame_end commits the old staged value; the new one
  // stays pending because pending is cleared before the write mask is OR'd.
  always_ff @(posedge clk) begin
    if (reset) begin
      staging   <= '0;
      live      <= '0;
      pending   <= '0;
      commit_q  <= 1'b0;
      err_count <= '0;
    end else begin
      commit_q <= bus.i_frame_end & (|pending);
      if (bus.i_frame_end) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (pending[k]) live[k] <= staging[k];
        end
      end
      pending <= (bus.i_frame_end ? 4'b0000 : pending) |
                 (accept ? (4'b0001 << shift[17:16]) : 4'b0000);
      if (accept) staging[shift[17:16]] <= shift[15:0];
      if (reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign bus.o_regs      = live;
  assign bus.o_pending   = pending;
  assign bus.o_commit    = commit_q;
  assign bus.o_err_count = err_count;

endmodule

// File: tb/tb_rbz_spi_regs.sv
// Self-checking bench for rbz_spi_regs: vector table plus hand-built corner
// sequences, with a commit scoreboard holding expected live register images.
module tb_rbz_spi_regs;
  localparam int unsigned SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rbz_spi_regs_if bus();

  rbz_spi_regs #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] staging_m [4];
  logic [15:0] regs_m    [4];
  logic [3:0]  pending_m;
  logic [63:0] exp_q [$];

  typedef struct {
    bit          is_fe;
    int          nbits;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [3:0]  exp_pending;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_regs();
    return {regs_m[3], regs_m[2], regs_m[1], regs_m[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      staging_m[k] = '0;
      regs_m[k]    = '0;
    end
    pending_m = '0;
    exp_q.delete();
  endtask

  task automatic model_commit(output bit fired);
    fired = (pending_m != 4'b0000);
    if (fired) begin
      for (int k = 0; k < 4; k++)
        if (pending_m[k]) regs_m[k] = staging_m[k];
      pending_m = '0;
      exp_q.push_back(pack_regs());
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [20:0] w, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      bus.i_mosi = w[20-i];
      wait_clks(4);
      bus.i_sclk = 1'b1;
      wait_clks(4);
      bus.i_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input int nbits, input logic [3:0] addr,
                            input logic [15:0] data, input bit fe_same);
    logic [20:0] w;
    bit fired;
    w = {addr, data, 1'b0};
    @(negedge clk);
    bus.i_ss_n = 1'b0;
    wait_clks(4);
    send_bits(w, 0, nbits);
    wait_clks(4);
    bus.i_ss_n = 1'b1;
    if (fe_same) begin
      // frame_end sampled on the same edge that takes the accepted write
      wait_clks(SYNC_STAGES);
      bus.i_frame_end = 1'b1;
      model_commit(fired);
      @(negedge clk);
      bus.i_frame_end = 1'b0;
      check("same_cycle_commit", {63'd0, bus.o_commit}, {63'd0, fired});
    end
    if (nbits == 20 && addr < 4'd4) begin
      staging_m[addr[1:0]] = data;
      pending_m[addr[1:0]] = 1'b1;
    end
    wait_clks(8);
  endtask

  task automatic pulse_fe();
    bit fired;
    @(negedge clk);
    bus.i_frame_end = 1'b1;
    model_commit(fired);
    @(negedge clk);
    bus.i_frame_end = 1'b0;
    check("commit_latency", {63'd0, bus.o_commit}, {63'd0, fired});
    @(negedge clk);
    check("commit_width", {63'd0, bus.o_commit}, 64'd0);
    check("pending_after_fe", {60'd0, bus.o_pending}, {60'd0, pending_m});
  endtask

  always @(negedge clk) begin
    if (bus.o_commit === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_commit", {63'd0, bus.o_commit}, 64'd0);
      else                   check("commit_regs", bus.o_regs, exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [20:0] w;
    tbl[0] = '{0, 20, 4'd2, 16'hBEEF, 4'b0100, 8'd0};
    tbl[1] = '{1,  0, 4'd0, 16'h0000, 4'b0000, 8'd0};
    tbl[2] = '{0, 20, 4'd0, 16'h1111, 4'b0001, 8'd0};
    tbl[3] = '{0, 20, 4'd0, 16'h2222, 4'b0001, 8'd0};
    tbl[4] = '{1,  0, 4'd0, 16'h0000, 4'b0000, 8'd0};
    tbl[5] = '{0, 19, 4'd1, 16'h1234, 4'b0000, 8'd1};
    tbl[6] = '{0, 21, 4'd1, 16'h1234, 4'b0000, 8'd2};
    tbl[7] = '{0, 20, 4'd7, 16'h1234, 4'b0000, 8'd3};
    tbl[8] = '{1,  0, 4'd0, 16'h0000, 4'b0000, 8'd3};
    tbl[9] = '{0, 20, 4'd3, 16'hABCD, 4'b1000, 8'd3};

    bus.i_sclk = 1'b0;
    bus.i_mosi = 1'b0;
    bus.i_ss_n = 1'b1;
    bus.i_frame_end = 1'b0;
    reset = 1'b1;
    model_reset();
    wait_clks(3);
    check("reset_regs", bus.o_regs, 64'd0);
    check("reset_pending", {60'd0, bus.o_pending}, 64'd0);
    check("reset_commit", {63'd0, bus.o_commit}, 64'd0);
    check("reset_err", {56'd0, bus.o_err_count}, 64'd0);
    reset = 1'b0;
    wait_clks(6);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_fe) pulse_fe();
      else send_frame(tbl[i].nbits, tbl[i].addr, tbl[i].data, 1'b0);
      check($sformatf("vec%0d_pending", i), {60'd0, bus.o_pending}, {60'd0, tbl[i].exp_pending});
      check($sformatf("vec%0d_err", i), {56'd0, bus.o_err_count}, {56'd0, tbl[i].exp_err});
      check($sformatf("vec%0d_regs", i), bus.o_regs, pack_regs());
    end
    check("reg2_beef", {48'd0, bus.o_regs[47:32]}, 64'hBEEF);
    check("reg0_last_write", {48'd0, bus.o_regs[15:0]}, 64'h2222);

    // accepted write to reg1 on the same edge as a frame_end committing reg3
    send_frame(20, 4'd1, 16'h5A5A, 1'b1);
    check("same_pending", {60'd0, bus.o_pending}, 64'b0010);
    check("same_reg3", {48'd0, bus.o_regs[63:48]}, 64'hABCD);
    check("same_reg1", {48'd0, bus.o_regs[31:16]}, 64'h0);
    pulse_fe();
    check("next_reg1", {48'd0, bus.o_regs[31:16]}, 64'h5A5A);

    // reset mid-transaction, with a frame_end pulse during reset
    send_frame(20, 4'd2, 16'h7777, 1'b0);
    check("pre_reset_pending", {60'd0, bus.o_pending}, 64'b0100);
    w = {4'd1, 16'hC3C3, 1'b0};
    @(negedge clk);
    bus.i_ss_n = 1'b0;
    wait_clks(4);
    send_bits(w, 0, 10);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    wait_clks(1);
    bus.i_frame_end = 1'b1;
    wait_clks(1);
    bus.i_frame_end = 1'b0;
    wait_clks(1);
    reset = 1'b0;
    send_bits(w, 10, 10);
    wait_clks(4);
    bus.i_ss_n = 1'b1;
    wait_clks(8);
    check("abandon_pending", {60'd0, bus.o_pending}, 64'd0);
    check("abandon_err", {56'd0, bus.o_err_count}, 64'd0);
    check("abandon_regs", bus.o_regs, 64'd0);
    pulse_fe();
    send_frame(20, 4'd1, 16'h1234, 1'b0);
    check("post_reset_pending", {60'd0, bus.o_pending}, 64'b0010);
    check("post_reset_err", {56'd0, bus.o_err_count}, 64'd0);

    // error counter saturation
    for (int i = 0; i < 254; i++) send_frame(1, 4'hF, 16'h0, 1'b0);
    check("err_254", {56'd0, bus.o_err_count}, 64'd254);
    send_frame(1, 4'hF, 16'h0, 1'b0);
    check("err_255", {56'd0, bus.o_err_count}, 64'd255);
    for (int i = 0; i < 5; i++) send_frame(1, 4'hF, 16'h0, 1'b0);
    check("err_sat", {56'd0, bus.o_err_count}, 64'd255);
    check("err_pending_kept", {60'd0, bus.o_pending}, 64'b0010);
    pulse_fe();
    check("final_reg1", {48'd0, bus.o_regs[31:16]}, 64'h1234);
    wait_clks(4);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rbz_spi_regs.md
RBZ_SPI_REGS -- requirements
Module: rbz_spi_regs

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (>=2) for i_sclk, i_mosi and i_ss_n.
REQ-002 SHALL have port clk  in  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous active-high reset.
REQ-004 SHALL have port i_sclk  in  1  SPI clock, asynchronous to clk, mode 0.
REQ-005 SHALL have port i_mosi  in  1  SPI data, MSB first, asynchronous to clk.
REQ-006 SHALL have port i_ss_n  in  1  SPI select, active-low, asynchronous to clk.
REQ-007 SHALL have port i_frame_end  in  1  one-clk pulse at the renderer frame boundary (vblank start).
REQ-008 SHALL have port o_regs  out  64  live registers; reg k occupies bits [16k+15:16k], k=0..3.
REQ-009 SHALL have port o_pending  out  4  bit k is high while reg k holds a staged value not yet committed.
REQ-010 SHALL have port o_commit  out  1  one-clk pulse on any cycle in which at least one register is committed.
REQ-011 SHALL have port o_err_count  out  8  saturating count of rejected SPI transactions.

Function
REQ-012 SHALL pass i_sclk, i_mosi and i_ss_n through SYNC_STAGES flops each, then through one further edge-detect register; all SPI decoding uses only the synchronized signals.
REQ-013 SHALL sample synchronized mosi on each synchronized sclk rising edge while synchronized ss_n is low; falling edges are ignored.
REQ-014 SHALL treat each ss_n low period as one transaction: 4-bit address, then 16 data bits, 20 bits total, MSB first.
REQ-015 SHALL hold a 5-bit bit counter that clears on the ss_n falling edge and saturates at 21.
REQ-016 SHALL accept a transaction only if the count is exactly 20 and the address is 0..3 when the ss_n rising edge is detected.
REQ-017 SHALL, on acceptance, write the 16 data bits into staging[addr] and set pending[addr] one clk after the ss_n rising edge is detected.
REQ-018 SHALL reject on a count not equal to 20 (short or long) or an address of 4..15; staging and pending are unchanged and o_err_count increments, saturating at 255.
REQ-019 SHALL let a second accepted write to the same address before commit overwrite staging; last write wins, with no error.
REQ-020 SHALL, on the cycle i_frame_end is high, copy every staging[k] with pending[k]=1 into live reg k, clear those pending bits, and raise o_commit on the following cycle; o_regs updates on that same following cycle.
REQ-021 SHALL keep o_commit low if i_frame_end arrives while pending=0.
REQ-022 SHALL commit the previous pending values when an accepted write and i_frame_end fall on the same cycle; the new write stays pending (pending bit =1) for the next frame_end.
REQ-023 SHALL never change o_regs except at a commit, so reg updates are frame-atomic.
REQ-024 SHALL require a clk frequency of at least 4x the sclk frequency; behaviour below that ratio is unspecified.
REQ-025 SHALL ignore sclk edges while ss_n is high.

Reset
REQ-026 SHALL, on reset, set o_regs=0, staging=0, o_pending=0, o_commit=0, o_err_count=0, bit counter=0 and all synchronizer/edge flops to the idle level (sclk=0, ss_n=1).
REQ-027 SHALL abandon any transaction in progress at reset with no error count; decoding resumes only after a fresh ss_n falling edge.
REQ-028 SHALL NOT produce a commit for any pulse on i_frame_end that coincides with reset.

Verification
REQ-029 SHALL cover: send addr=2, data=16'hBEEF, then pulse i_frame_end -> o_pending=4'b0100 before the pulse; one clk after, o_regs[47:32]=16'hBEEF, o_commit=1 for one clk, o_pending=0.
REQ-030 SHALL cover: send a 19-bit frame, a 21-bit frame and an addr=7 frame -> o_err_count=3, o_pending=0, o_regs unchanged.
REQ-031 SHALL cover: writes addr0=16'h1111 then addr0=16'h2222, then frame_end -> reg0=16'h2222, o_err_count=0.
REQ-032 SHALL cover: an accepted write to addr1 landing on the same cycle as an i_frame_end that commits a pending addr3 -> reg3 updates, reg1 unchanged, o_pending=4'b0010; the next frame_end commits reg1.
REQ-033 SHALL cover: assert reset after 10 bits of a transaction, then complete the remaining bits without re-asserting ss_n -> no pending, no error; the next full frame is accepted.
REQ-034 SHALL cover: 260 bad frames -> o_err_count holds at 255.
